muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Multi-cycle multiply/divide sequencer for the MIPS core's HI/LO unit. It executes MULT, MULTU, DIV and DIVU over 32 iterations using one shift-add/subtract datapath. It reports divide-by-zero through the existing 32-bit zero detector. The block sits beside the ALU; the control unit stalls on `busy` and commits HI/LO on `done`.

## Interface
- `WIDTH`, 32: operand width. Only 32 is supported.
- `clk`  in  1: rising-edge clock, the only clock.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: launch request. Sampled only in IDLE.
- `op`  in  2: operation. 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a`  in  32: multiplicand / dividend. Sampled with `start`.
- `b`  in  32: multiplier / divisor. Sampled with `start`.
- `busy`  out  1: operation in progress.
- `done`  out  1: one-cycle pulse; `hi`/`lo` valid from this cycle on.
- `div_zero`  out  1: with `done`, DIV/DIVU had `b == 0`.
- `hi`  out  32: product[63:32], or remainder.
- `lo`  out  32: product[31:0], or quotient.

## Operation
- States:
  - IDLE: waits for `start`.
  - CALC: 32 iterations, 5-bit counter 0..31.
  - SIGN: sign fix-up and HI/LO write.
- IDLE + `start`:
  - Latch `op`.
  - Latch magnitudes: |a|, |b| for signed ops; raw values for unsigned ops.
  - Latch `neg_q` = a[31]^b[31] (signed ops only) and `neg_r` = a[31] (DIV only).
- IDLE + `start` with divide op and `b == 0`:
  - Stay in IDLE.
  - Next cycle: `done`=1, `div_zero`=1.
  - `hi`/`lo` unchanged.
- Otherwise IDLE + `start` goes to CALC.
- Multiply path:
  - 64-bit accumulator, shift-add on the multiplier LSB, one bit per cycle.
  - Magnitudes only.
- Divide path:
  - Restoring division with a 33-bit partial remainder and the quotient shifted into the low register, one bit per cycle.
  - Magnitudes only.
- CALC with counter == 31 goes to SIGN.
- SIGN:
  - Multiply: negate the 64-bit product if `neg_q`.
  - Divide: negate the quotient if `neg_q`; negate the remainder if `neg_r`.
  - Write `hi`/`lo`, pulse `done`, go to IDLE.
- DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0, no flag.
- `start` while not in IDLE is ignored. There is no queueing.
- `hi`/`lo` hold their value until the next SIGN write or reset.
- `rst` at any time, including mid-CALC:
  - State goes to IDLE; the in-flight operation is discarded.
  - `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0.

## Timing
- `start` is sampled at edge N.
- Normal operation:
  - `busy`=1 from after edge N until edge N+33.
  - CALC iterations occur at edges N+1..N+32.
  - SIGN writes at edge N+33.
  - `done`=1 for the single cycle between N+33 and N+34; `busy`=0 in that cycle.
  - `start` is accepted in the `done` cycle (back-to-back ops, 33-cycle throughput).
- Divide-by-zero:
  - `done`=1 and `div_zero`=1 in the cycle after edge N.
  - `busy` stays 0.
- `div_zero` is 0 whenever `done` is 0.
- All outputs are registered.

## Structure
- Shared header `muldiv_defs.v`: op encodings (`OP_MULTU`..`OP_DIV`), state encodings, iteration count 32.
- Sub-module: instantiate the existing `zero_32` on `b` for divide-by-zero detection. No other sub-modules.
- Single FSM with one datapath. The negate logic is shared between the MULT and DIV sign fix-up.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` exactly 33 edges after `start`, `busy` high 33 cycles.
- MULT 0xFFFFFFFD × 0x00000007 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- Division results:
  - DIVU 100 / 7 → `lo`=14, `hi`=2.
  - DIV 0xFFFFFFF9 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Divide-by-zero:
  - Setup: `hi`/`lo` preloaded by MULTU 3 × 5 (`lo`=15, `hi`=0).
  - Stimulus: DIVU 0x1234 / 0.
  - Required: `done`=1 and `div_zero`=1 one edge after `start`; `busy` never 1; `hi`=0, `lo`=15 unchanged.
- Back-to-back and ignored `start`:
  - `start` pulsed again at CALC cycle 5 with different operands → ignored; result is that of the first op.
  - New `start` in the `done` cycle → accepted; its `done` arrives 33 edges later.
- `rst` asserted at CALC iteration 10 → next cycle `busy`=0, `done`=0, `hi`=`lo`=0; a following MULTU 6 × 7 gives `lo`=42.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared op/state encodings and iteration count for the HI/LO sequencer
package muldiv_seq_pkg;
  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_SIGN = 2'b10
  } state_e;
  localparam int ITERS = 32;
endpackage

// File: rtl/muldiv_seq_zero.sv
// zero_32: flags an all-zero 32-bit word
module zero_32 (
  input  logic [31:0] in_i,
  output logic        zero_o
);
  assign zero_o = ~|in_i;
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: 32-iteration shift-add multiply / restoring divide with sign fix-up
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] ph_q, ph_d, pl_q, pl_d, opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic             b_zero;
  logic [WIDTH-1:0] a_mag, b_mag, neg_lo, neg_hi;
  logic [WIDTH:0]   add_sum, trial, diff;

  zero_32 u_zero (.in_i(b), .zero_o(b_zero));

  assign a_mag   = (op[0] & a[WIDTH-1]) ? -a : a;
  assign b_mag   = (op[0] & b[WIDTH-1]) ? -b : b;
  // ph holds the product high half (multiply) or the partial remainder (divide)
  assign add_sum = {1'b0, ph_q} + (pl_q[0] ? {1'b0, opb_q} : '0);
  assign trial   = {ph_q, pl_q[WIDTH-1]};
  assign diff    = trial - {1'b0, opb_q};
  // one negator serves both: low half is -pl; high half is -ph for divide or
  // the upper word of the 64-bit negation (carry only when pl is zero) for multiply
  assign neg_lo  = -pl_q;
  assign neg_hi  = ~ph_q + {{(WIDTH-1){1'b0}}, op_q[1] | (pl_q == '0)};

  // state register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MULTU;
      cnt_q     <= '0;
      ph_q      <= '0;
      pl_q      <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      ph_q      <= ph_d;
      pl_q      <= pl_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  // next-state, iteration step and sign fix-up
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    ph_d      = ph_q;
    pl_d      = pl_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        if (op[1] && b_zero) begin
          done_d = 1'b1;
          dz_d   = 1'b1;
        end else begin
          state_d   = S_CALC;
          op_d      = op_e'(op);
          cnt_d     = '0;
          ph_d      = '0;
          pl_d      = op[1] ? a_mag : b_mag;
          opb_d     = op[1] ? b_mag : a_mag;
          neg_quo_d = op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = (op == OP_DIV) & a[WIDTH-1];
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (op_q[1]) begin
          ph_d = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
          pl_d = {pl_q[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
          {ph_d, pl_d} = {add_sum, pl_q[WIDTH-1:1]};
        end
        state_d = (cnt_q == 5'(ITERS - 1)) ? S_SIGN : S_CALC;
      end
      S_SIGN: begin
        hi_d    = (op_q[1] ? neg_rem_q : neg_quo_q) ? neg_hi : ph_q;
        lo_d    = neg_quo_q ? neg_lo : pl_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = state_d != S_IDLE;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed checks of multiply, divide, divide-by-zero, start handling and reset
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;
  int          checks = 0;
  int          errors = 0;
  int          edges, busy_cycles;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int bc);
    n = 0; bc = busy ? 1 : 0;
    while (1) begin
      @(posedge clk); #1;
      n++;
      if (busy) bc++;
      if (done) return;
      if (n >= 100) begin n = -1; return; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b want 0", div_zero); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
    rst = 1'b0;
  endtask

  task automatic test_multu;
    launch(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(edges, busy_cycles);
    checks++; if (edges !== 33) begin errors++; $display("FAIL multu_latency: got %0d want 33", edges); end
    checks++; if (busy_cycles !== 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 33", busy_cycles); end
    checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
    checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", lo); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL multu_dz: got %b want 0", div_zero); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_in_done: got %b want 0", busy); end
  endtask

  task automatic test_mult;
    launch(2'b01, 32'hFFFFFFFD, 32'h00000007);
    wait_done(edges, busy_cycles);
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
  endtask

  task automatic test_div;
    launch(2'b10, 32'd100, 32'd7);
    wait_done(edges, busy_cycles);
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h want 0000000e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h want 00000002", hi); end
    launch(2'b11, 32'hFFFFFFF9, 32'd2);
    wait_done(edges, busy_cycles);
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
    launch(2'b11, 32'h80000000, 32'hFFFFFFFF);
    wait_done(edges, busy_cycles);
    checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h want 00000000", hi); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL div_ovf_dz: got %b want 0", div_zero); end
  endtask

  task automatic test_div_zero;
    launch(2'b00, 32'd3, 32'd5);
    wait_done(edges, busy_cycles);
    checks++; if (lo !== 32'd15) begin errors++; $display("FAIL dz_preload_lo: got %h want 0000000f", lo); end
    @(posedge clk); #1;
    launch(2'b10, 32'h1234, 32'h0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL dz_done: got %b want 1", done); end
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b want 1", div_zero); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dz_busy: got %b want 0", busy); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL dz_hi: got %h want 00000000", hi); end
    checks++; if (lo !== 32'd15) begin errors++; $display("FAIL dz_lo: got %h want 0000000f", lo); end
    @(posedge clk); #1;
    checks++; if ({done, div_zero, busy} !== 3'b000) begin errors++; $display("FAIL dz_after: got %b want 000", {done, div_zero, busy}); end
  endtask

  task automatic test_ignored_start;
    launch(2'b00, 32'h00010000, 32'h00010000);
    repeat (5) @(posedge clk);
    #1;
    launch(2'b10, 32'd9, 32'd3);
    wait_done(edges, busy_cycles);
    checks++; if (edges !== 27) begin errors++; $display("FAIL ignored_latency: got %0d want 27", edges); end
    checks++; if (hi !== 32'h1) begin errors++; $display("FAIL ignored_hi: got %h want 00000001", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL ignored_lo: got %h want 00000000", lo); end
  endtask

  task automatic test_back_to_back;
    launch(2'b00, 32'd2, 32'd3);
    wait_done(edges, busy_cycles);
    checks++; if (lo !== 32'd6) begin errors++; $display("FAIL b2b_first_lo: got %h want 00000006", lo); end
    launch(2'b10, 32'd50, 32'd8);
    wait_done(edges, busy_cycles);
    checks++; if (edges !== 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", edges); end
    checks++; if (lo !== 32'd6) begin errors++; $display("FAIL b2b_lo: got %h want 00000006", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL b2b_hi: got %h want 00000002", hi); end
  endtask

  task automatic test_rst_mid;
    launch(2'b10, 32'd100, 32'd7);
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b want 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rst_mid_hi: got %h want 00000000", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rst_mid_lo: got %h want 00000000", lo); end
    rst = 1'b0;
    @(posedge clk); #1;
    launch(2'b00, 32'd6, 32'd7);
    wait_done(edges, busy_cycles);
    checks++; if (edges !== 33) begin errors++; $display("FAIL rst_after_latency: got %0d want 33", edges); end
    checks++; if (lo !== 32'd42) begin errors++; $display("FAIL rst_after_lo: got %h want 0000002a", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rst_after_hi: got %h want 00000000", hi); end
  endtask

  initial begin
    test_reset;
    test_multu;
    test_mult;
    test_div;
    test_div_zero;
    test_ignored_start;
    test_back_to_back;
    test_rst_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
